// File: rtl/shift_seq_pkg.sv
// Shared types for the serial shift-chain sequencer: state encoding and counter sizing.
package shift_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  function automatic int cnt_width(input int width, input int depth);
    return $clog2(width + depth + 2);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// Serialises a word LSB-first into an external DEPTH-flop chain and reassembles it from the chain output.
// Optional even-parity trailer bit and parity_err output under SHIFT_SEQ_CTRL_PARITY_EN.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sh_d,
  input  logic             sh_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH, DEPTH);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  localparam int PAR_CYC = 1;
`else
  localparam int PAR_CYC = 0;
`endif
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1 + PAR_CYC);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(WIDTH + DEPTH - 1 + PAR_CYC);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_out_data;
  logic             r_sh_d;
  logic             r_out_vld;
  logic             r_in_rdy;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  logic             r_par_err;
`endif

  logic [CW-1:0]    w_c_nxt;
  logic             w_nxt_bit;

  assign w_c_nxt = r_cnt + CW'(1);

  // sh_d is registered, so the bit for cycle c+1 is selected during cycle c.
  always_comb begin
    w_nxt_bit = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (w_c_nxt == CW'(k)) w_nxt_bit = r_data[k];
    end
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    if (w_c_nxt == CW'(WIDTH)) w_nxt_bit = ^r_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_data     <= '0;
      r_out_data <= '0;
      r_sh_d     <= 1'b0;
      r_out_vld  <= 1'b0;
      r_in_rdy   <= 1'b0;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
      r_par_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_in_rdy <= 1'b1;
          if (in_valid && r_in_rdy) begin
            r_data   <= in_data;
            r_sh_d   <= in_data[0];
            r_cnt    <= '0;
            r_in_rdy <= 1'b0;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
            r_par_err <= 1'b0;
`endif
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_cnt <= w_c_nxt;
          if (r_cnt == LAST_SHIFT) begin
            r_sh_d  <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_sh_d  <= w_nxt_bit;
          end
        end
        DRAIN: begin
          r_cnt <= w_c_nxt;
          if (r_cnt == LAST_DRAIN) begin
            r_out_vld <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Bit k emerges from the chain DEPTH cycles after it was driven.
      if (r_state == SHIFT || r_state == DRAIN) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (r_cnt == CW'(k + DEPTH)) r_out_data[k] <= sh_q;
        end
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
        if (r_cnt == CW'(WIDTH + DEPTH)) r_par_err <= sh_q ^ (^r_out_data);
`endif
      end
    end
  end

  assign in_ready  = r_in_rdy;
  assign sh_d      = r_sh_d;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_data;
  assign busy      = (r_state != IDLE);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  assign parity_err = r_par_err;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl at WIDTH=8 with DEPTH 4, 1 and 16; each instance has its own chain model.
module tb_shift_seq_ctrl;

  localparam int W = 8;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_vld  [3];
  logic [W-1:0] in_dat  [3];
  logic         in_rdy  [3];
  logic         sh_d    [3];
  logic         sh_q    [3];
  logic         out_vld [3];
  logic         out_rdy [3];
  logic [W-1:0] out_dat [3];
  logic         busy    [3];
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  logic         par_err [3];
`endif
  logic [15:0]  ch [3];
  logic         inv = 1'b0;

  int errs  = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  // External chains: sh_q is the output of flop DEPTH; instance 0 can have its output inverted.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) ch[i] <= {ch[i][14:0], sh_d[i]};
  end
  assign sh_q[0] = ch[0][3] ^ inv;
  assign sh_q[1] = ch[1][0];
  assign sh_q[2] = ch[2][15];

  shift_seq_ctrl #(.WIDTH(W), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_vld[0]), .in_data(in_dat[0]), .in_ready(in_rdy[0]),
    .sh_d(sh_d[0]), .sh_q(sh_q[0]), .out_valid(out_vld[0]), .out_ready(out_rdy[0]),
    .out_data(out_dat[0]),
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    .parity_err(par_err[0]),
`endif
    .busy(busy[0]));

  shift_seq_ctrl #(.WIDTH(W), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_vld[1]), .in_data(in_dat[1]), .in_ready(in_rdy[1]),
    .sh_d(sh_d[1]), .sh_q(sh_q[1]), .out_valid(out_vld[1]), .out_ready(out_rdy[1]),
    .out_data(out_dat[1]),
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    .parity_err(par_err[1]),
`endif
    .busy(busy[1]));

  shift_seq_ctrl #(.WIDTH(W), .DEPTH(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_vld[2]), .in_data(in_dat[2]), .in_ready(in_rdy[2]),
    .sh_d(sh_d[2]), .sh_q(sh_q[2]), .out_valid(out_vld[2]), .out_ready(out_rdy[2]),
    .out_data(out_dat[2]),
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    .parity_err(par_err[2]),
`endif
    .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word to instance i; returns cycles waited for in_ready and edges from accept to out_valid.
  task automatic run_word(input int i, input logic [W-1:0] d, output int waited, output int lat);
    waited = 0;
    while (!in_rdy[i] && waited < 50) begin
      tick();
      waited++;
    end
    in_dat[i] = d;
    in_vld[i] = 1'b1;
    tick();
    in_vld[i] = 1'b0;
    lat = 0;
    while (!out_vld[i] && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] word;
    int waited;
    int lat;
    for (int i = 0; i < 3; i++) begin
      in_vld[i]  = 1'b0;
      in_dat[i]  = '0;
      out_rdy[i] = 1'b0;
      ch[i]      = '0;
    end

    // Reset state
    #12;
    chk("rst_in_ready", in_rdy[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_out_valid", out_vld[0], 0);
    chk("rst_sh_d", sh_d[0], 0);
    chk("rst_out_data", out_dat[0], 0);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    chk("rst_parity_err", par_err[0], 0);
`endif
    #1 rst_n = 1'b1;
    tick();
    chk("rel_in_ready", in_rdy[0], 1);

    // 8'hA5 serialised LSB first: 1,0,1,0,0,1,0,1
    word = 8'hA5;
    in_dat[0] = word;
    in_vld[0] = 1'b1;
    tick();
    in_vld[0] = 1'b0;
    chk("a5_busy", busy[0], 1);
    chk("a5_in_ready", in_rdy[0], 0);
    for (int c = 0; c < W; c++) begin
      chk($sformatf("a5_sh_d_c%0d", c), sh_d[0], word[c]);
      tick();
    end
    chk("a5_sh_d_after", sh_d[0], 0);
    for (int c = W; c < 11 + PAR; c++) tick();
    chk("a5_vld_early", out_vld[0], 0);
    tick();
    chk("a5_vld_12", out_vld[0], 1);
    chk("a5_data", out_dat[0], 8'hA5);

    // Hold in DONE; in_valid offered meanwhile must be ignored
    in_dat[0] = 8'hFF;
    in_vld[0] = 1'b1;
    for (int h = 0; h < 5; h++) begin
      tick();
      chk("hold_vld", out_vld[0], 1);
      chk("hold_data", out_dat[0], 8'hA5);
      chk("hold_in_ready", in_rdy[0], 0);
    end
    in_vld[0] = 1'b0;
    out_rdy[0] = 1'b1;
    tick();
    out_rdy[0] = 1'b0;
    chk("rel_vld", out_vld[0], 0);
    chk("rel_in_rdy", in_rdy[0], 1);
    chk("rel_busy", busy[0], 0);

    // Reset during SHIFT at c=3 (bit 3 of 8'hFF is 1)
    in_dat[0] = 8'hFF;
    in_vld[0] = 1'b1;
    tick();
    in_vld[0] = 1'b0;
    tick(); tick(); tick();
    chk("mid_sh_d_pre", sh_d[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_sh_d", sh_d[0], 0);
    chk("mid_busy", busy[0], 0);
    chk("mid_vld", out_vld[0], 0);
    chk("mid_in_rdy", in_rdy[0], 0);
    #1 rst_n = 1'b1;
    tick();
    chk("mid_rel_in_rdy", in_rdy[0], 1);
    run_word(0, 8'h3C, waited, lat);
    chk("3c_lat", lat, 12 + PAR);
    chk("3c_data", out_dat[0], 8'h3C);
    out_rdy[0] = 1'b1;
    tick();

    // Back-to-back with out_ready held high
    run_word(0, 8'hFF, waited, lat);
    chk("b2b_ff_lat", lat, 12 + PAR);
    chk("b2b_ff_data", out_dat[0], 8'hFF);
    tick();
    chk("b2b_idle_rdy", in_rdy[0], 1);
    chk("b2b_idle_vld", out_vld[0], 0);
    run_word(0, 8'h01, waited, lat);
    chk("b2b_01_wait", waited, 0);
    chk("b2b_01_lat", lat, 12 + PAR);
    chk("b2b_01_data", out_dat[0], 8'h01);
    tick();
    out_rdy[0] = 1'b0;

    // DEPTH extremes
    out_rdy[1] = 1'b1;
    run_word(1, 8'h5A, waited, lat);
    chk("d1_lat", lat, 9 + PAR);
    chk("d1_data", out_dat[1], 8'h5A);
    out_rdy[2] = 1'b1;
    run_word(2, 8'h5A, waited, lat);
    chk("d16_lat", lat, 24 + PAR);
    chk("d16_data", out_dat[2], 8'h5A);
    tick();
    chk("d16_idle", busy[2], 0);

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    // Parity of 8'h07 is 1; invert the chain output only at the parity sample (c=12)
    in_dat[0] = 8'h07;
    in_vld[0] = 1'b1;
    tick();
    in_vld[0] = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    inv = 1'b1;
    tick();
    inv = 1'b0;
    chk("par_vld", out_vld[0], 1);
    chk("par_err_forced", par_err[0], 1);
    chk("par_data", out_dat[0], 8'h07);
    out_rdy[0] = 1'b1;
    tick();
    out_rdy[0] = 1'b0;
    run_word(0, 8'h07, waited, lat);
    chk("par_lat", lat, 13);
    chk("par_err_clean", par_err[0], 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the parallel word width in bits (legal range 2..32).
REQ-002 Parameter DEPTH, default 4, SHALL set the flop count of the external serial shift chain (legal range 1..16).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL flag that a word is offered on in_data.
REQ-006 in_data  input  WIDTH  SHALL carry the parallel word to serialise.
REQ-007 in_ready  output  1  SHALL flag that the block accepts a word this cycle.
REQ-008 sh_d  output  1  SHALL drive the serial input of the shift chain.
REQ-009 sh_q  input  1  SHALL receive the serial output of the shift chain.
REQ-010 out_valid  output  1  SHALL flag that out_data holds a captured word.
REQ-011 out_ready  input  1  SHALL flag that the consumer takes out_data this cycle.
REQ-012 out_data  output  WIDTH  SHALL carry the word reassembled from sh_q.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, DRAIN and DONE.
REQ-015 in_ready SHALL be high only in IDLE; a word is accepted on a rising edge with in_valid && in_ready, and the FSM moves IDLE->SHIFT on that edge.
REQ-016 Cycle counter c SHALL be 0 in the first SHIFT cycle and SHALL increment by 1 per cycle through SHIFT and DRAIN.
REQ-017 In SHIFT, sh_d SHALL equal the latched in_data[c], LSB first, for c = 0..WIDTH-1; SHIFT->DRAIN SHALL occur at the end of c = WIDTH-1.
REQ-018 In every state other than SHIFT, sh_d SHALL be 0.
REQ-019 sh_q SHALL be sampled at the end of cycle c = k+DEPTH into out_data[k], for k = 0..WIDTH-1.
REQ-020 DRAIN->DONE SHALL occur at the end of c = WIDTH+DEPTH-1, so total latency from the accept edge to out_valid is WIDTH+DEPTH cycles.
REQ-021 Where DEPTH exceeds WIDTH, sampling SHALL still follow REQ-019 and cover the whole window; no sample is skipped.
REQ-022 In DONE, out_valid SHALL be high and out_data SHALL be stable until an edge with out_ready high; DONE->IDLE SHALL occur on that edge.
REQ-023 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-024 Back-to-back words SHALL be possible with one IDLE cycle between DONE and the next SHIFT.

Reset
REQ-025 Asserting rst_n low SHALL immediately force IDLE, c=0, sh_d=0, out_valid=0, out_data=0 and busy=0, including mid-SHIFT or mid-DRAIN.
REQ-026 in_ready SHALL be 0 while rst_n is low and SHALL go to 1 in the first cycle after release.

Configuration
REQ-027 With SHIFT_SEQ_CTRL_PARITY_EN defined, SHIFT SHALL last WIDTH+1 cycles, with sh_d = even parity of in_data at c = WIDTH, and all later timing SHALL shift by one cycle.
REQ-028 With SHIFT_SEQ_CTRL_PARITY_EN defined, the parity bit SHALL be sampled at c = WIDTH+DEPTH, and an output parity_err (1 bit, valid with out_valid, reset 0) SHALL flag a mismatch.
REQ-029 Without SHIFT_SEQ_CTRL_PARITY_EN, the parity_err port and its logic SHALL be absent and timing SHALL be as in REQ-017..REQ-020.

Structure
REQ-030 Package shift_seq_pkg SHALL hold the state enum, the state encoding constants and a counter-width function of clog2(WIDTH+DEPTH+2).
REQ-031 The block SHALL be a single module with no sub-module; the shift chain stays external.

Verification
REQ-032 WIDTH=8, DEPTH=4, in_data=8'hA5 accepted -> sh_d = 1,0,1,0,0,1,0,1 over c=0..7; out_valid rises 12 cycles after accept with out_data=8'hA5.
REQ-033 out_ready held low for 5 cycles in DONE -> out_valid stays high, out_data=8'hA5 stable, in_ready=0; the first out_ready edge returns the FSM to IDLE.
REQ-034 rst_n pulsed low at c=3 of SHIFT -> next sample shows sh_d=0, busy=0, out_valid=0; a new word 8'h3C then completes correctly.
REQ-035 Words 8'hFF and 8'h01 sent back-to-back with out_ready=1 -> both returned in order, second accept exactly one IDLE cycle after the first DONE.
REQ-036 DEPTH=1 and DEPTH=16 with in_data=8'h5A -> out_data=8'h5A after 9 and 24 cycles respectively.
REQ-037 With SHIFT_SEQ_CTRL_PARITY_EN, in_data=8'h07 and sh_q forced inverted during the parity sample -> parity_err=1; unforced -> parity_err=0.
